// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg
// Shared definitions for the two-requester UART transmit scheduler:
//   - state_e        : 2-bit FSM state encoding (IDLE=0, LOAD=1, WAIT=2, GAP=3)
//   - UART_BIT_TIME  : clocks per UART bit-time
//   - DEF_*_CYCLES   : default frame length and inter-frame gap
//   - cnt_width()    : width of the slot counter for a given frame/gap length
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam int UART_BIT_TIME      = 16;
    // 11 bit-times per frame: start, 8 data, parity, stop
    localparam int DEF_FRAME_CYCLES   = 11 * UART_BIT_TIME;
    localparam int DEF_GAP_CYCLES     = 16;

    // Counter only ever holds (length - 1), so $clog2(max length) bits suffice;
    // never narrower than one bit so the minimum-length case still synthesises.
    function automatic int cnt_width(input int frame_cycles, input int gap_cycles);
        int m;
        m = (frame_cycles > gap_cycles) ? frame_cycles : gap_cycles;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter2.sv
// rr_arbiter2
// Combinational two-way round-robin picker.
//   valid[1:0]  in  : request lines
//   last_grant  in  : requester that won the previous arbitration
//   grant[1:0]  out : one-hot winner (all zero when nothing is valid)
//   grant_id    out : index of the winner (echoes last_grant when idle)
module rr_arbiter2
    import uart_tx_sched_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant,
    output logic       grant_id
);

    // Pick the sole requester, or on contention the one that did not win last time
    always_comb begin
        grant    = 2'b00;
        grant_id = last_grant;
        case (valid)
            2'b01: begin
                grant    = 2'b01;
                grant_id = 1'b0;
            end
            2'b10: begin
                grant    = 2'b10;
                grant_id = 1'b1;
            end
            2'b11: begin
                if (last_grant) begin
                    grant    = 2'b01;
                    grant_id = 1'b0;
                end else begin
                    grant    = 2'b10;
                    grant_id = 1'b1;
                end
            end
            default: begin
                grant    = 2'b00;
                grant_id = last_grant;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Round-robin scheduler in front of a byte-serial UART transmitter that has no
// busy/done output. A chosen byte is presented on tx_data with a one-cycle
// tx_cmd pulse, then held for the whole frame plus an idle gap.
//   clk, rst (async, active-low)
//   reqN_valid/reqN_data in, reqN_ready out : valid/ready byte sources 0 and 1
//   tx_data, tx_cmd                          : to transmitter datain/tcmd
//   busy, grant_id, frame_done               : status
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int FRAME_CYCLES = DEF_FRAME_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [7:0] tx_data,
    output logic       tx_cmd,
    output logic       busy,
    output logic       grant_id,
    output logic       frame_done
);

    localparam int CW = cnt_width(FRAME_CYCLES, GAP_CYCLES);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_cmd_q, tx_cmd_d;
    logic            frame_done_q, frame_done_d;
    logic            last_grant_q, last_grant_d;

    logic [1:0]      arb_grant_s;
    logic            arb_id_s;
    logic            idle_s;
    logic            accept_s;

    rr_arbiter2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (arb_grant_s),
        .grant_id   (arb_id_s)
    );

    // Accepting is only possible in IDLE; the winner is always a valid requester
    always_comb begin
        idle_s     = (state_q == ST_IDLE);
        accept_s   = idle_s && (arb_grant_s != 2'b00);
        // rst term keeps ready low while reset is held, even though state reads IDLE
        req0_ready = rst && idle_s && arb_grant_s[0];
        req1_ready = rst && idle_s && arb_grant_s[1];
    end

    // Next-state, slot counter and output register inputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        tx_cmd_d     = 1'b0;
        frame_done_d = 1'b0;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    tx_data_d    = arb_id_s ? req1_data : req0_data;
                    last_grant_d = arb_id_s;
                    // Registered, so the pulse lands in the LOAD cycle
                    tx_cmd_d     = 1'b1;
                    state_d      = ST_LOAD;
                end else begin
                    state_d      = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cnt_d   = CW'(FRAME_CYCLES - 1);
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q == CW'(1'b0)) begin
                    cnt_d   = CW'(GAP_CYCLES - 1);
                    state_d = ST_GAP;
                end else begin
                    cnt_d   = cnt_q - CW'(1'b1);
                end
            end
            ST_GAP: begin
                if (cnt_q == CW'(1'b0)) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d        = cnt_q - CW'(1'b1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; last_grant resets to 1 so requester 0 wins first contention
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CW'(1'b0);
            tx_data_q    <= 8'h00;
            tx_cmd_q     <= 1'b0;
            frame_done_q <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            tx_cmd_q     <= tx_cmd_d;
            frame_done_q <= frame_done_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_cmd     = tx_cmd_q;
    assign frame_done = frame_done_q;
    assign grant_id   = last_grant_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// Self-checking bench: expected (grant, byte, tx_cmd cycle) entries are queued
// when stimulus is driven and compared when tx_cmd fires. A second instance
// with FRAME_CYCLES=GAP_CYCLES=1 checks the minimum-parameter cadence.
module tb_uart_tx_sched;

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic [7:0] tx_data;
    logic       tx_cmd, busy, grant_id, frame_done;

    logic       m_valid;
    logic       m_ready0, m_ready1;
    logic [7:0] m_tx_data;
    logic       m_tx_cmd, m_busy, m_grant_id, m_frame_done;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   fd_count = 0;
    int   m_cnt = 0;
    int   m_last = 0;
    logic m_exp_id = 1'b0;
    logic prev_cmd = 1'b0;
    exp_t sb_q[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_sched dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_data(tx_data), .tx_cmd(tx_cmd), .busy(busy),
        .grant_id(grant_id), .frame_done(frame_done)
    );

    uart_tx_sched #(.FRAME_CYCLES(1), .GAP_CYCLES(1)) dut_min (
        .clk(clk), .rst(rst),
        .req0_valid(m_valid), .req0_data(8'hC1), .req0_ready(m_ready0),
        .req1_valid(m_valid), .req1_data(8'hC2), .req1_ready(m_ready1),
        .tx_data(m_tx_data), .tx_cmd(m_tx_cmd), .busy(m_busy),
        .grant_id(m_grant_id), .frame_done(m_frame_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at the negedge right after an accept edge (cyc == acc); returns at frame_done.
    task automatic wait_frame(input int acc, input logic [7:0] hold);
        int busy_n = 0;
        bit held = 1'b1;
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_n++;
            if (tx_data !== hold) held = 1'b0;
            @(negedge clk);
        end
        check_eq("fd_seen", 32'(seen), 32'd1);
        check_eq("fd_cycle", cyc, acc + 193);
        check_eq("busy_cycles", busy_n, 32'd193);
        check_eq("data_hold", 32'(held), 32'd1);
    endtask

    // Scoreboard monitor for the default-parameter instance
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (tx_cmd) begin
                    check_eq("cmd_gap", 32'(prev_cmd), 32'd0);
                    if (sb_q.size() == 0) begin
                        check_eq("sb_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("tx_data", 32'(tx_data), 32'(e.data));
                        check_eq("grant_id", 32'(grant_id), 32'(e.id));
                        check_eq("cmd_cycle", cyc, e.cyc);
                    end
                end
                if (frame_done) fd_count++;
            end
            prev_cmd = tx_cmd;
        end
    end

    // Minimum-parameter instance: 4-cycle cadence, alternating grants from 0
    initial begin
        forever begin
            @(negedge clk);
            if (rst && m_tx_cmd) begin
                if (m_cnt > 0) check_eq("min_spacing", cyc - m_last, 32'd4);
                check_eq("min_grant", 32'(m_grant_id), 32'(m_exp_id));
                check_eq("min_data", 32'(m_tx_data), m_exp_id ? 32'hC2 : 32'hC1);
                m_exp_id = ~m_exp_id;
                m_last   = cyc;
                m_cnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        bit got;
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = 8'h00; req1_data = 8'h00;
        m_valid = 1'b0;

        // Reset values, and readiness suppressed while reset is held
        repeat (3) @(negedge clk);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_eq("rst_tx_data", 32'(tx_data), 32'h00);
        check_eq("rst_tx_cmd", 32'(tx_cmd), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd1);
        check_eq("rst_fd", 32'(frame_done), 32'd0);
        check_eq("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Minimum parameters
        @(negedge clk);
        m_valid = 1'b1;
        repeat (40) @(negedge clk);
        m_valid = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("min_count", m_cnt, 32'd10);

        // Contention: both held valid for four frames
        @(negedge clk);
        req0_data = 8'h11; req1_data = 8'h22;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_eq("cont_ready", 32'({req1_ready, req0_ready}), 32'b01);
        a = cyc + 1;
        sb_q.push_back('{1'b0, 8'h11, a});
        sb_q.push_back('{1'b1, 8'h22, a + 194});
        sb_q.push_back('{1'b0, 8'h11, a + 388});
        sb_q.push_back('{1'b1, 8'h22, a + 582});
        repeat (583) @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_frame(cyc, 8'h22);

        // Single request
        @(negedge clk);
        req0_data = 8'hA5; req0_valid = 1'b1;
        #1;
        check_eq("single_ready", 32'({req1_ready, req0_ready}), 32'b01);
        sb_q.push_back('{1'b0, 8'hA5, cyc + 1});
        @(negedge clk);
        req0_valid = 1'b0;
        check_eq("single_busy", 32'(busy), 32'd1);
        wait_frame(cyc, 8'hA5);

        // Data hold: requester changes data after accept
        @(negedge clk);
        req0_data = 8'h3C; req0_valid = 1'b1;
        sb_q.push_back('{1'b0, 8'h3C, cyc + 1});
        @(negedge clk);
        req0_valid = 1'b0; req0_data = 8'hFF;
        wait_frame(cyc, 8'h3C);

        // Late arrival: req0 shows up mid-frame and must wait for IDLE
        @(negedge clk);
        req1_data = 8'h66; req1_valid = 1'b1;
        sb_q.push_back('{1'b1, 8'h66, cyc + 1});
        @(negedge clk);
        a = cyc;
        req1_valid = 1'b0;
        repeat (50) @(negedge clk);
        req0_data = 8'h5A; req0_valid = 1'b1;
        sb_q.push_back('{1'b0, 8'h5A, a + 194});
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (req0_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("late_ready_seen", 32'(got), 32'd1);
        check_eq("late_ready_cycle", cyc, a + 193);
        @(negedge clk);
        req0_valid = 1'b0;
        wait_frame(cyc, 8'h5A);

        // Reset mid-frame aborts the slot; requester 0 wins first afterwards
        @(negedge clk);
        req1_data = 8'h77; req1_valid = 1'b1;
        sb_q.push_back('{1'b1, 8'h77, cyc + 1});
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mid_tx_data", 32'(tx_data), 32'h00);
        check_eq("mid_tx_cmd", 32'(tx_cmd), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_grant", 32'(grant_id), 32'd1);
        req0_data = 8'h11; req1_data = 8'h22;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check_eq("mid_ready", 32'({req1_ready, req0_ready}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("post_rst_ready", 32'({req1_ready, req0_ready}), 32'b01);
        sb_q.push_back('{1'b0, 8'h11, cyc + 1});
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_frame(cyc, 8'h11);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb_q.size(), 32'd0);
        check_eq("fd_total", fd_count, 32'd9);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Two-requester scheduler in front of the byte-serial UART transmitter (`datain`/`tcmd`/`tx`) in the USB loopback design. It accepts bytes from two sources over valid/ready, arbitrates round-robin, and presents the chosen byte on `tx_data` with a one-cycle `tx_cmd` pulse. It then holds `tx_data` stable for the full frame plus an inter-frame gap, because the transmitter samples `datain` live and has no done/busy output.

## Interface
Parameters:
- `FRAME_CYCLES`, 176, clocks the transmitter needs per frame (11 bit-times × 16); must be ≥1.
- `GAP_CYCLES`, 16, idle clocks forced between frames; must be ≥1.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req0_valid`  in  1  requester 0 has a byte.
- `req0_data`  in  8  requester 0 byte.
- `req0_ready`  out  1  requester 0 byte accepted this cycle.
- `req1_valid`  in  1  requester 1 has a byte.
- `req1_data`  in  8  requester 1 byte.
- `req1_ready`  out  1  requester 1 byte accepted this cycle.
- `tx_data`  out  8  byte to transmitter `datain`, registered.
- `tx_cmd`  out  1  one-cycle start pulse to transmitter `tcmd`, registered.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  1  requester that owns the current or last frame.
- `frame_done`  out  1  one-cycle pulse when a frame slot ends.

## Operation
- FSM states: IDLE, LOAD, WAIT, GAP.
- IDLE:
  - If any `reqN_valid` is high, pick the winner.
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to `last_grant` wins.
  - `reqN_ready` is combinational and high only for the winner, only in IDLE.
  - Transfer occurs on valid && ready.
  - On the same edge: `tx_data` <= winner data, `grant_id`/`last_grant` <= winner, go to LOAD.
- LOAD (1 cycle):
  - `tx_cmd` = 1.
  - Load counter with FRAME_CYCLES−1, go to WAIT.
- WAIT (FRAME_CYCLES cycles):
  - `tx_cmd` = 0.
  - Counter decrements each cycle.
  - At 0: load GAP_CYCLES−1, go to GAP.
- GAP (GAP_CYCLES cycles):
  - Counter decrements.
  - At 0: go to IDLE and assert `frame_done` for the first IDLE cycle.
- Readiness outside IDLE:
  - Both `reqN_ready` stay 0 in LOAD/WAIT/GAP regardless of valid.
  - A requester keeps valid/data held until it sees ready.
- `tx_data` changes only on an accept edge; requester data changes after accept have no effect.
- Counter width is $clog2(max(FRAME_CYCLES, GAP_CYCLES)) bits, minimum 1; unsigned decrement, never wraps (state changes at 0).
- Reset values (async, immediate on `rst` low):
  - state IDLE.
  - `tx_data` 8'h00.
  - `tx_cmd` 0.
  - `frame_done` 0.
  - `grant_id` 1.
  - `last_grant` 1, so requester 0 wins the first contended arbitration.
  - counter 0.
  - `busy` 0.
  - `reqN_ready` 0 while in reset.
- Reset mid-frame aborts the slot: no `frame_done`, no further `tx_cmd`. Deassertion is synchronised by the system reset tree.

## Timing
- Accept at edge 0 → `tx_cmd` high during cycle 1 → WAIT cycles 2..F+1 → GAP cycles F+2..F+G+1 → IDLE at cycle F+G+2 with `frame_done`=1.
- Minimum spacing between accepts: F+G+2 cycles, i.e. 194 at defaults.
- An accept may occur in the same cycle `frame_done` is high.
- `busy` is high from cycle 1 through F+G+1.
- `tx_cmd` is never high on two consecutive cycles.
- Simultaneous valid in IDLE resolves by round-robin only; a valid arriving during a frame waits until IDLE.

## Structure
- Package `uart_tx_sched_pkg`:
  - state encoding (2-bit: IDLE=0, LOAD=1, WAIT=2, GAP=3).
  - default FRAME_CYCLES/GAP_CYCLES constants.
  - UART bit-time constant 16.
- Sub-module `rr_arbiter2`: combinational two-way round-robin picker; inputs `valid[1:0]`, `last_grant`; outputs `grant[1:0]` one-hot and `grant_id`.
- Top holds the FSM, counter and output registers.

## Test plan
- **Single request:** req0 byte 8'hA5 alone → `req0_ready` high same cycle; `tx_data`=8'hA5 and `tx_cmd` high exactly 1 cycle at cycle 1; `busy` high 193 cycles; one `frame_done` at cycle 194.
- **Contention:** req0=8'h11 and req1=8'h22 both held valid continuously → grants 0,1,0,1; `tx_data` 11,22,11,22; accepts at cycles 0, 194, 388, 582.
- **Late arrival:** req1 valid alone, then req0 valid at cycle 50 → `req0_ready` stays 0 until cycle 194, then req0 is accepted there.
- **Data hold:** after accepting 8'h3C, requester drives 8'hFF → `tx_data` stays 8'h3C through cycle 193.
- **Reset mid-frame:** `rst` low at cycle 100 of a frame → all outputs at reset values immediately, no `frame_done`. After release, with both valid, requester 0 wins first.
- **Minimum parameters:** FRAME_CYCLES=1, GAP_CYCLES=1, both requesters valid → accept spacing 4 cycles, alternating grants, `tx_cmd` period 4.
